mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-ported memory between an instruction-fetch
// port and a data port. One access is in flight at a time; each access walks
// IDLE -> ISSUE -> WAIT -> DONE, so a request sampled in IDLE completes
// WAIT+2 cycles later and back-to-back accesses run every WAIT+3 cycles.
// When both ports request in the same IDLE cycle, the port that did not win
// the previous grant is served (round-robin on lastGnt).
//
// Parameters
//   WAIT      memory read latency in cycles (1..4), issue edge to memRdata valid
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   iReq/iAddr             fetch request and address
//   iData/iValid/iStall    registered fetch data, completion pulse, stall
//   dReq/dWrite/dAddr/dWdata  data request, direction, address, write data
//   dRdata/dValid/dStall   registered read data, completion pulse, stall
//   memEn/memWrite/memAddr/memWdata  memory strobe/control, zero outside ISSUE
//   memRdata               memory read data
//   busy                   high whenever the FSM is not in IDLE
module mem_arbiter #(
  parameter int WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iReq,
  input  logic [15:0] iAddr,
  output logic [15:0] iData,
  output logic        iValid,
  output logic        iStall,
  input  logic        dReq,
  input  logic        dWrite,
  input  logic [15:0] dAddr,
  input  logic [15:0] dWdata,
  output logic [15:0] dRdata,
  output logic        dValid,
  output logic        dStall,
  output logic        memEn,
  output logic        memWrite,
  output logic [15:0] memAddr,
  output logic [15:0] memWdata,
  input  logic [15:0] memRdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // WAIT-1 is at most 3, so two bits cover every legal latency.
  localparam int          CW       = 2;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT - 1);

  state_t        state, state_nxt;
  port_t         last_gnt;     // winner of the most recent grant
  port_t         gnt;          // owner of the access in flight
  port_t         gnt_nxt;      // arbitration result for this IDLE cycle
  logic          lat_write;
  logic [15:0]   lat_addr;
  logic [15:0]   lat_wdata;
  logic [CW-1:0] cnt;

  // Arbitration: a lone requester wins; on contention the port that lost
  // last time wins.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    gnt_nxt = PORT_I;
    if (dReq && (!iReq || last_gnt == PORT_I)) begin
      gnt_nxt = PORT_D;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (iReq || dReq) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from state; the memory bus is driven only in ISSUE
  // and is forced to zero otherwise so the memory never sees stale control.
  always_comb begin
    memEn    = 1'b0;
    memWrite = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    if (state == ST_ISSUE) begin
      memEn    = 1'b1;
      memWrite = lat_write;
      memAddr  = lat_addr;
      memWdata = lat_wdata;
    end
  end

  assign iValid = (state == ST_DONE) && (gnt == PORT_I);
  assign dValid = (state == ST_DONE) && (gnt == PORT_D);
  assign iStall = iReq & ~iValid;
  assign dStall = dReq & ~dValid;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    if (reset) begin
      // NOTE: the returned-data registers are cleared on reset because they
      // are visible outputs with a defined post-reset value, not scratch storage.
      state     <= ST_IDLE;
      last_gnt  <= PORT_I;
      gnt       <= PORT_I;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      iData     <= '0;
      dRdata    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        ST_IDLE: begin
          if (iReq || dReq) begin
            gnt      <= gnt_nxt;
            last_gnt <= gnt_nxt;
            if (gnt_nxt == PORT_D) begin
              lat_addr  <= dAddr;
              lat_write <= dWrite;
              lat_wdata <= dWrite ? dWdata : '0;
            end else begin
              lat_addr  <= iAddr;
              lat_write <= 1'b0;
              lat_wdata <= '0;
            end
          end
        end
        ST_ISSUE: cnt <= CNT_LOAD;
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!lat_write) begin
            // Final WAIT cycle: memRdata is valid now. Writes leave dRdata alone.
            if (gnt == PORT_I) iData  <= memRdata;
            else               dRdata <= memRdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
